// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 8-digit display scanner.
// Imported by the frame buffer and the scan controller.
package disp_pkg;

  localparam int N_DIG = 8;
  localparam int SEG_W = 7;

  localparam logic [7:0] AN_OFF  = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  function automatic logic [7:0] an_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/disp_frame_buf.sv
// Shadow/active double buffer: frames land in the shadow and are
// promoted to the active copy only at a frame boundary.
module disp_frame_buf
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid_i,
  output logic        frame_ready_o,
  input  logic [55:0] frame_data_i,
  input  logic [7:0]  frame_mask_i,
  input  logic        swap_i,
  output logic [55:0] act_data_o,
  output logic [7:0]  act_mask_o
);

  logic        full_q, full_d;
  logic        ready_q, ready_d;
  logic [55:0] shd_data_q, shd_data_d;
  logic [7:0]  shd_mask_q, shd_mask_d;
  logic [55:0] act_data_q, act_data_d;
  logic [7:0]  act_mask_q, act_mask_d;
  logic        load;
  logic        do_swap;

  assign load    = frame_valid_i & ready_q;
  assign do_swap = swap_i & full_q;

  // Load needs an empty shadow and swap a full one, so they never collide.
  always_comb begin
    full_d     = full_q;
    shd_data_d = shd_data_q;
    shd_mask_d = shd_mask_q;
    act_data_d = act_data_q;
    act_mask_d = act_mask_q;
    if (load) begin
      full_d     = 1'b1;
      shd_data_d = frame_data_i;
      shd_mask_d = frame_mask_i;
    end
    if (do_swap) begin
      full_d     = 1'b0;
      act_data_d = shd_data_q;
      act_mask_d = shd_mask_q;
    end
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 1'b0;
      ready_q    <= 1'b1;
      shd_data_q <= '1;
      shd_mask_q <= '0;
      act_data_q <= '1;
      act_mask_q <= '0;
    end else begin
      full_q     <= full_d;
      ready_q    <= ready_d;
      shd_data_q <= shd_data_d;
      shd_mask_q <= shd_mask_d;
      act_data_q <= act_data_d;
      act_mask_q <= act_mask_d;
    end
  end

  assign frame_ready_o = ready_q;
  assign act_data_o    = act_data_q;
  assign act_mask_o    = act_mask_q;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scanner with per-slot blanking
// and a double-buffered frame input.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [55:0] frame_data,
  input  logic [7:0]  frame_mask,
  output logic [7:0]  AN,
  output logic [6:0]  led,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    led_q, led_d;
  logic          fd_q, fd_d;
  logic          boundary;
  logic [55:0]   act_data;
  logic [7:0]    act_mask;
  logic          lit;

  disp_frame_buf u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_valid_i (frame_valid),
    .frame_ready_o (frame_ready),
    .frame_data_i  (frame_data),
    .frame_mask_i  (frame_mask),
    .swap_i        (boundary),
    .act_data_o    (act_data),
    .act_mask_o    (act_mask)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            idx_d    = idx_q + 3'd1;
            state_d  = BLANK;
            boundary = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next state so the flops line up with it.
  assign lit = (state_d == DRIVE) && act_mask[idx_d];

  always_comb begin
    an_d  = AN_OFF;
    led_d = SEG_OFF;
    unique case (1'b1)
      lit: begin
        an_d  = an_sel(idx_d);
        led_d = act_data[int'(idx_d)*SEG_W +: SEG_W];
      end
      default: begin
        an_d  = AN_OFF;
        led_d = SEG_OFF;
      end
    endcase
    fd_d = (state_d == DRIVE) && (idx_d == 3'd7)
        && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      an_q    <= AN_OFF;
      led_q   <= SEG_OFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      led_q   <= led_d;
      fd_q    <= fd_d;
    end
  end

  assign AN         = an_q;
  assign led        = led_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomized bench for disp_scan_ctrl against a slot-arithmetic model.
// Runs with SCAN_DIV=10, BLANK_CYC=2.
module tb_disp_scan_ctrl;

  localparam int SD = 10;
  localparam int BC = 2;
  localparam int FP = SD * 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        frame_valid;
  logic        frame_ready;
  logic [55:0] frame_data;
  logic [7:0]  frame_mask;
  logic [7:0]  AN;
  logic [6:0]  led;
  logic        frame_done;

  int n_chk;
  int n_err;

  bit          m_run;
  int          m_t;
  bit          m_full;
  logic [55:0] m_sdata, m_adata;
  logic [7:0]  m_smask, m_amask;

  disp_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_mask  (frame_mask),
    .AN          (AN),
    .led         (led),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_run   = 0;
    m_t     = 0;
    m_full  = 0;
    m_sdata = '1;
    m_smask = '0;
    m_adata = '1;
    m_amask = '0;
  endtask

  // One clock: drive, check at negedge, advance model, land at posedge+1.
  task automatic cyc(input bit en, input bit vld,
                     input logic [55:0] dat, input logic [7:0] msk);
    logic [7:0] ea;
    logic [6:0] el;
    bit ef, take;
    int d, ph;
    enable      = en;
    frame_valid = vld;
    frame_data  = dat;
    frame_mask  = msk;
    @(negedge clk);
    ea = 8'hFF;
    el = 7'h7F;
    ef = 0;
    if (m_run) begin
      d  = (m_t / SD) % 8;
      ph = m_t % SD;
      ef = (m_t % FP) == FP - 1;
      if (ph >= BC && m_amask[d]) begin
        ea = 8'hFF ^ (8'd1 << d);
        el = m_adata[7*d +: 7];
      end
    end
    chk("an", 64'(AN), 64'(ea));
    chk("led", 64'(led), 64'(el));
    chk("frame_done", 64'(frame_done), 64'(ef));
    chk("frame_ready", 64'(frame_ready), 64'(!m_full));
    take = vld && !m_full;
    if (!en) begin
      m_run = 0;
      m_t   = 0;
    end else if (!m_run) begin
      m_run = 1;
      m_t   = 0;
    end else begin
      if ((m_t % FP) == FP - 1 && m_full) begin
        m_adata = m_sdata;
        m_amask = m_smask;
        m_full  = 0;
      end
      m_t++;
    end
    if (take) begin
      m_sdata = dat;
      m_smask = msk;
      m_full  = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cyc(en, 0, '0, '0);
  endtask

  // Run until the model reaches frame position pos (bounded).
  task automatic wait_pos(input int pos);
    bit found;
    found = 0;
    for (int i = 0; i < 4 * FP; i++) begin
      if (m_run && (m_t % FP) == pos) begin
        found = 1;
        break;
      end
      cyc(1, 0, '0, '0);
    end
    chk("wait_pos", 64'(found), 64'd1);
  endtask

  function automatic logic [55:0] pat(input int base);
    logic [55:0] v;
    for (int i = 0; i < 8; i++) v[7*i +: 7] = 7'(base + i);
    return v;
  endfunction

  initial begin
    n_chk       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    frame_mask  = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 64'(AN), 64'hFF);
    chk("rst_led", 64'(led), 64'h7F);
    chk("rst_fd", 64'(frame_done), 64'd0);
    chk("rst_ready", 64'(frame_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // no frame loaded: dark display, periodic frame_done
    run(2, 0);
    run(2 * FP + 5, 1);

    // frame of 7'h40+i, all digits lit
    cyc(1, 1, pat(7'h40), 8'hFF);
    run(2 * FP, 1);

    // second frame offered during digit 3
    wait_pos(3 * SD + 4);
    cyc(1, 1, pat(7'h10), 8'hFF);
    run(FP + 10, 1);

    // alternate digits masked
    cyc(1, 1, pat(7'h20), 8'b1010_1010);
    run(2 * FP, 1);

    // drop enable in DRIVE of digit 5, then re-enable
    wait_pos(5 * SD + 4);
    run(3, 0);
    run(FP + 20, 1);

    // async reset mid-DRIVE with a full shadow
    wait_pos(3 * SD + 3);
    cyc(1, 1, pat(7'h30), 8'hFF);
    wait_pos(4 * SD + 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_an", 64'(AN), 64'hFF);
    chk("arst_led", 64'(led), 64'h7F);
    chk("arst_ready", 64'(frame_ready), 64'd1);
    chk("arst_fd", 64'(frame_done), 64'd0);
    m_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2 * FP, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [55:0] rd;
      bit en, vld;
      rd  = {24'($urandom), $urandom};
      en  = ($urandom_range(0, 149) != 0);
      vld = ($urandom_range(0, 3) == 0);
      cyc(en, vld, rd, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
